// File: rtl/main_fsm_if.sv
// Control-unit handshake bundle: instruction fields and FPU done in,
// datapath strobes, mux selects and the FPU watchdog flag out.
interface main_fsm_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       FPUDone;
  logic       IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp, FPUWrite;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic       FPUTimeout;

  modport master (
    output Op, Funct, FPUDone,
    input  IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp, FPUWrite,
    input  ALUSrcA, ALUSrcB, ResultSrc, FPUTimeout
  );

  modport slave (
    input  Op, Funct, FPUDone,
    output IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp, FPUWrite,
    output ALUSrcA, ALUSrcB, ResultSrc, FPUTimeout
  );
endinterface

// File: rtl/main_fsm.sv
// Multicycle Moore control FSM with an FPU issue/wait path guarded by a
// 32-cycle watchdog whose timeout flag is sticky until reset.
module main_fsm (
  input  logic       clk,
  input  logic       reset,
  main_fsm_if.slave  bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_FPUSTART = 4'd10,
    S_FPUWAIT  = 4'd11,
    S_FPUWB    = 4'd12
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic       tmo_q, tmo_d;

  logic       ir_write, adr_src, next_pc, reg_w, mem_w, branch, alu_op, fpu_write;
  logic [1:0] alu_src_a, alu_src_b, result_src;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= 5'd0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d    = S_FETCH;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    next_pc    = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    branch     = 1'b0;
    alu_op     = 1'b0;
    fpu_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    case (state_q)
      S_FETCH: begin
        ir_write  = 1'b1;
        next_pc   = 1'b1;
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        case (bus.Op)
          2'b00:   state_d = bus.Funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FPUSTART;
        endcase
      end
      S_MEMADR: begin
        alu_src_b = 2'b01;
        state_d   = bus.Funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        adr_src = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_w      = 1'b1;
      end
      S_MEMWR: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
      end
      S_EXECUTER: begin
        alu_op  = 1'b1;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_op    = 1'b1;
        alu_src_b = 2'b01;
        state_d   = S_ALUWB;
      end
      S_ALUWB: reg_w = 1'b1;
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        branch    = 1'b1;
      end
      S_FPUSTART: begin
        fpu_write = 1'b1;
        cnt_d     = 5'd0;
        state_d   = S_FPUWAIT;
      end
      S_FPUWAIT: begin
        // done beats the watchdog when both land in the same cycle
        if (bus.FPUDone) begin
          state_d = S_FPUWB;
        end else if (cnt_q == 5'd31) begin
          tmo_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + 5'd1;
          state_d = S_FPUWAIT;
        end
      end
      S_FPUWB: begin
        result_src = 2'b10;
        reg_w      = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign bus.IRWrite    = ir_write;
  assign bus.AdrSrc     = adr_src;
  assign bus.NextPC     = next_pc;
  assign bus.RegW       = reg_w;
  assign bus.MemW       = mem_w;
  assign bus.Branch     = branch;
  assign bus.ALUOp      = alu_op;
  assign bus.FPUWrite   = fpu_write;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ResultSrc  = result_src;
  assign bus.FPUTimeout = tmo_q;

endmodule

// File: doc/main_fsm.md
MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset, sampled on rising clk edge.
REQ-003 SHALL have port Op, input, 2, instruction class (00 data-proc, 01 memory, 10 branch, 11 FPU).
REQ-004 SHALL have port Funct, input, 6, instruction Funct field; bit5 = immediate, bit0 = load.
REQ-005 SHALL have port FPUDone, input, 1, FPU completion pulse.
REQ-006 SHALL have ports IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp, FPUWrite, output, 1 each, datapath strobes and selects.
REQ-007 SHALL have ports ALUSrcA, ALUSrcB, ResultSrc, output, 2 each, datapath mux selects; ResultSrc 00 ALUOut, 01 read data, 10 FPU result.
REQ-008 SHALL have port FPUTimeout, output, 1, sticky FPU watchdog flag.

Function
REQ-009 SHALL implement a Moore FSM; all outputs except FPUTimeout decode from the registered state only; every output not listed for a state is 0.
REQ-010 SHALL hold states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH, FPUSTART, FPUWAIT, FPUWB (4-bit encoding, unused codes go to FETCH next cycle with all outputs 0).
REQ-011 FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=00, NextPC=1; next DECODE.
REQ-012 DECODE: ALUSrcA=01, ALUSrcB=10; next by Op: 00 and Funct[5]=0 -> EXECUTER; 00 and Funct[5]=1 -> EXECUTEI; 01 -> MEMADR; 10 -> BRANCH; 11 -> FPUSTART.
REQ-013 MEMADR: ALUSrcA=00, ALUSrcB=01; next MEMRD if Funct[0]=1, else MEMWR.
REQ-014 MEMRD: AdrSrc=1, ResultSrc=00; next MEMWB. MEMWB: ResultSrc=01, RegW=1; next FETCH.
REQ-015 MEMWR: AdrSrc=1, ResultSrc=00, MemW=1; next FETCH.
REQ-016 EXECUTER: ALUSrcA=00, ALUSrcB=00, ALUOp=1; EXECUTEI: same but ALUSrcB=01; both next ALUWB.
REQ-017 ALUWB: ResultSrc=00, RegW=1; next FETCH.
REQ-018 BRANCH: ALUSrcA=10, ALUSrcB=01, ResultSrc=00, Branch=1; next FETCH.
REQ-019 FPUSTART: FPUWrite=1 for exactly one cycle; clears 5-bit watchdog counter to 0; next FPUWAIT; FPUDone ignored in this state.
REQ-020 FPUWAIT: all strobes 0; FPUDone=1 -> FPUWB; else counter increments by 1 per cycle; FPUDone=0 with counter=31 -> FETCH and FPUTimeout set to 1.
REQ-021 FPUDone=1 and counter=31 in same FPUWAIT cycle: done wins, go FPUWB, FPUTimeout unchanged.
REQ-022 FPUWB: ResultSrc=10, RegW=1; next FETCH.
REQ-023 FPUTimeout SHALL remain 1 until reset; not cleared by later successful FPU operations.
REQ-024 Latencies (FETCH to FETCH): branch 3, data-proc 4, store 4, load 5, FPU 4+N cycles where N = FPUWAIT cycles (1..32).

Reset
REQ-025 reset=1 at a clock edge SHALL force state FETCH, counter 0, FPUTimeout 0, regardless of current state (including mid-FPUWAIT).
REQ-026 While reset=1 outputs SHALL show FETCH decode from the cycle after the first reset edge; first post-reset cycle is FETCH.
REQ-027 reset SHALL take priority over FPUDone and all transitions in the same cycle.

Verification
REQ-028 Reset then Op=00, Funct=000000 -> FETCH, DECODE, EXECUTER (ALUOp=1, ALUSrcB=00), ALUWB (RegW=1), FETCH.
REQ-029 Op=01, Funct[0]=1 -> MEMADR, MEMRD (AdrSrc=1), MEMWB (ResultSrc=01, RegW=1); Funct[0]=0 -> MEMWR with MemW=1 for one cycle.
REQ-030 Op=11, FPUDone asserted on 3rd FPUWAIT cycle -> FPUWrite=1 one cycle, 3 FPUWAIT cycles, FPUWB with ResultSrc=10, RegW=1, FPUTimeout=0.
REQ-031 Op=11, FPUDone held 0 -> exactly 32 FPUWAIT cycles, then FETCH, FPUTimeout=1, RegW never asserted; next FPU op with done leaves FPUTimeout=1.
REQ-032 FPUDone=1 exactly on 32nd FPUWAIT cycle -> FPUWB taken, FPUTimeout stays 0.
REQ-033 reset asserted during FPUWAIT with FPUTimeout=1 -> next state FETCH, FPUTimeout=0, counter 0.
